// File: rtl/draw_pkg.sv
`default_nettype none
// ============================================================================
// Module  : draw_pkg
// Brief   : Shared FSM state encoding and default geometry for image blitters.
// Revision: 1.0  initial release
// ============================================================================
package draw_pkg;

  localparam int DEFAULT_H_RES = 160;
  localparam int DEFAULT_V_RES = 120;
  localparam int DEFAULT_COL_W = 3;
  localparam int IMG_WORDS     = DEFAULT_H_RES * DEFAULT_V_RES;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } draw_state_t;

endpackage
`default_nettype wire

// File: rtl/raster_scan_counter.sv
`default_nettype none
// ============================================================================
// Module  : raster_scan_counter
// Brief   : Row-major x/y/address generator; address advances by one per inc.
// Revision: 1.0  initial release
// ============================================================================
module raster_scan_counter
  import draw_pkg::*;
#(
  parameter int H_RES  = DEFAULT_H_RES,
  parameter int V_RES  = DEFAULT_V_RES,
  parameter int X_W    = 8,
  parameter int Y_W    = 7,
  parameter int ADDR_W = 17
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              clear,
  input  logic              inc,
  input  logic [ADDR_W-1:0] base,
  output logic [X_W-1:0]    x,
  output logic [Y_W-1:0]    y,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [X_W-1:0]    r_x;
  logic [Y_W-1:0]    r_y;
  logic [ADDR_W-1:0] r_addr;
  logic              w_x_end;

  assign w_x_end = (r_x == X_W'(H_RES - 1));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_x    <= '0;
      r_y    <= '0;
      r_addr <= '0;
    end else if (clear) begin
      r_x    <= '0;
      r_y    <= '0;
      r_addr <= base;
    end else if (inc) begin
      r_addr <= r_addr + ADDR_W'(1);
      if (w_x_end) begin
        r_x <= '0;
        r_y <= r_y + Y_W'(1);
      end else begin
        r_x <= r_x + X_W'(1);
      end
    end
  end

  assign x    = r_x;
  assign y    = r_y;
  assign addr = r_addr;
  assign last = w_x_end && (r_y == Y_W'(V_RES - 1));

endmodule
`default_nettype wire

// File: rtl/draw_image_engine.sv
`default_nettype none
// ============================================================================
// Module  : draw_image_engine
// Brief   : Full-screen ROM-to-VGA image blitter, one pixel per clock.
//           Optional macro TRANSPARENT_KEY_EN suppresses KEY_COL pixels.
// Revision: 1.0  initial release
// ============================================================================
module draw_image_engine
  import draw_pkg::*;
#(
  parameter int H_RES   = DEFAULT_H_RES,
  parameter int V_RES   = DEFAULT_V_RES,
  parameter int X_W     = 8,
  parameter int Y_W     = 7,
  parameter int COL_W   = DEFAULT_COL_W,
  parameter int NUM_IMG = 3,
  parameter int SEL_W   = 2,
  parameter int ADDR_W  = 17,
  parameter int ROM_LAT = 1
`ifdef TRANSPARENT_KEY_EN
  ,
  parameter int KEY_COL = 0
`endif
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  input  logic              abort,
  input  logic [SEL_W-1:0]  img_sel,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [COL_W-1:0]  rom_data,
  output logic [X_W-1:0]    out_x,
  output logic [Y_W-1:0]    out_y,
  output logic [COL_W-1:0]  out_col,
  output logic              plot,
  output logic              busy,
  output logic              done
);

  localparam int c_img_words = H_RES * V_RES;
  localparam int c_drain_w   = $clog2(ROM_LAT + 2);

  draw_state_t r_state, w_state_nxt;

  logic                          w_accept, w_busy, w_flush, w_last, w_inc;
  logic                          w_drain_end, w_tail_v, w_plot_nxt;
  logic [SEL_W-1:0]              w_sel;
  logic [ADDR_W-1:0]             w_base;
  logic [X_W-1:0]                w_x;
  logic [Y_W-1:0]                w_y;
  logic [c_drain_w-1:0]          r_drain_cnt;
  logic [ROM_LAT-1:0]            r_pv;
  logic [ROM_LAT-1:0][X_W-1:0]   r_px;
  logic [ROM_LAT-1:0][Y_W-1:0]   r_py;
  logic [X_W-1:0]                r_out_x;
  logic [Y_W-1:0]                r_out_y;
  logic [COL_W-1:0]              r_out_col;
  logic                          r_plot;

  // Out-of-range selections fall back to the last stored image.
  assign w_sel    = (int'(img_sel) > NUM_IMG - 1) ? SEL_W'(NUM_IMG - 1) : img_sel;
  assign w_base   = ADDR_W'(w_sel) * ADDR_W'(c_img_words);

  assign w_accept    = (r_state == IDLE) && start;
  assign w_busy      = (r_state == RUN) || (r_state == DRAIN);
  assign w_flush     = w_busy && abort;
  assign w_inc       = (r_state == RUN) && !w_last;
  assign w_drain_end = (r_drain_cnt == c_drain_w'(ROM_LAT));
  assign w_tail_v    = r_pv[ROM_LAT-1];

  raster_scan_counter #(
    .H_RES  (H_RES),
    .V_RES  (V_RES),
    .X_W    (X_W),
    .Y_W    (Y_W),
    .ADDR_W (ADDR_W)
  ) u_scan (
    .clock  (clock),
    .resetn (resetn),
    .clear  (w_accept),
    .inc    (w_inc),
    .base   (w_base),
    .x      (w_x),
    .y      (w_y),
    .addr   (rom_addr),
    .last   (w_last)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = RUN;
      RUN:     if (abort) w_state_nxt = IDLE;
               else if (w_last) w_state_nxt = DRAIN;
      DRAIN:   if (abort) w_state_nxt = IDLE;
               else if (w_drain_end) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)                 r_drain_cnt <= '0;
    else if (r_state != DRAIN)   r_drain_cnt <= '0;
    else                         r_drain_cnt <= r_drain_cnt + c_drain_w'(1);
  end

  // Coordinates ride alongside the ROM read so the tail lines up with rom_data.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_pv <= '0;
      r_px <= '0;
      r_py <= '0;
    end else begin
      r_pv[0] <= (r_state == RUN);
      r_px[0] <= w_x;
      r_py[0] <= w_y;
      for (int i = 1; i < ROM_LAT; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_px[i] <= r_px[i-1];
        r_py[i] <= r_py[i-1];
      end
      if (w_flush) r_pv <= '0;
    end
  end

`ifdef TRANSPARENT_KEY_EN
  assign w_plot_nxt = w_tail_v && !w_flush && (rom_data != COL_W'(KEY_COL));
`else
  assign w_plot_nxt = w_tail_v && !w_flush;
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_plot    <= 1'b0;
      r_out_x   <= '0;
      r_out_y   <= '0;
      r_out_col <= '0;
    end else begin
      r_plot <= w_plot_nxt;
      if (w_plot_nxt) begin
        r_out_x   <= r_px[ROM_LAT-1];
        r_out_y   <= r_py[ROM_LAT-1];
        r_out_col <= rom_data;
      end
    end
  end

  assign out_x   = r_out_x;
  assign out_y   = r_out_y;
  assign out_col = r_out_col;
  assign plot    = r_plot;
  assign busy    = w_busy;
  assign done    = (r_state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_draw_image_engine.sv
`default_nettype none
// ============================================================================
// Module  : tb_draw_image_engine
// Brief   : Directed bench: two engines (ROM latency 1 and 3) on a 4x3 image.
// Revision: 1.0  initial release
// ============================================================================
module tb_draw_image_engine;

  localparam int H = 4;
  localparam int V = 3;
  localparam int W = H * V;
`ifdef TRANSPARENT_KEY_EN
  localparam bit KEYED = 1'b1;
`else
  localparam bit KEYED = 1'b0;
`endif

  logic        clock   = 1'b0;
  logic        resetn  = 1'b0;
  logic        start   = 1'b0;
  logic        abort   = 1'b0;
  logic [1:0]  img_sel = 2'd0;

  logic [16:0] rom_addr_a, rom_addr_b;
  logic [2:0]  rom_data_a, rom_data_b;
  logic [7:0]  out_x_a, out_x_b;
  logic [6:0]  out_y_a, out_y_b;
  logic [2:0]  out_col_a, out_col_b;
  logic        plot_a, plot_b, busy_a, busy_b, done_a, done_b;

  always #5 clock = ~clock;

  draw_image_engine #(
    .H_RES(H), .V_RES(V), .X_W(8), .Y_W(7), .COL_W(3),
    .NUM_IMG(3), .SEL_W(2), .ADDR_W(17), .ROM_LAT(1)
  ) u_dut_a (
    .clock(clock), .resetn(resetn), .start(start), .abort(abort),
    .img_sel(img_sel), .rom_addr(rom_addr_a), .rom_data(rom_data_a),
    .out_x(out_x_a), .out_y(out_y_a), .out_col(out_col_a),
    .plot(plot_a), .busy(busy_a), .done(done_a)
  );

  draw_image_engine #(
    .H_RES(H), .V_RES(V), .X_W(8), .Y_W(7), .COL_W(3),
    .NUM_IMG(3), .SEL_W(2), .ADDR_W(17), .ROM_LAT(3)
  ) u_dut_b (
    .clock(clock), .resetn(resetn), .start(start), .abort(abort),
    .img_sel(img_sel), .rom_addr(rom_addr_b), .rom_data(rom_data_b),
    .out_x(out_x_b), .out_y(out_y_b), .out_col(out_col_b),
    .plot(plot_b), .busy(busy_b), .done(done_b)
  );

  // Address-pattern ROMs: colour is the low address bits.
  logic [2:0] ra_q, rb_q0, rb_q1, rb_q2;
  always @(posedge clock) begin
    ra_q  <= rom_addr_a[2:0];
    rb_q0 <= rom_addr_b[2:0];
    rb_q1 <= rb_q0;
    rb_q2 <= rb_q1;
  end
  assign rom_data_a = ra_q;
  assign rom_data_b = rb_q2;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int          np_a, np_b, nd_a, nd_b, run_a, run_b, dc_a, dc_b, nb_a;
  logic [31:0] log_a [16];
  logic [31:0] log_b [16];
  logic [16:0] ra_log [16];
  logic        busy_a_q = 1'b0, busy_b_q = 1'b0;

  always @(negedge clock) begin
    if (busy_a && !busy_a_q) run_a = cyc;
    if (busy_b && !busy_b_q) run_b = cyc;
    if (busy_a) begin
      if (nb_a < 16) ra_log[nb_a] = rom_addr_a;
      nb_a++;
    end
    if (plot_a) begin
      if (np_a < 16) log_a[np_a] = {out_x_a, 1'b0, out_y_a, 5'b0, out_col_a, 8'(cyc - run_a)};
      np_a++;
    end
    if (plot_b) begin
      if (np_b < 16) log_b[np_b] = {out_x_b, 1'b0, out_y_b, 5'b0, out_col_b, 8'(cyc - run_b)};
      np_b++;
    end
    if (done_a) begin nd_a++; dc_a = cyc - run_a; end
    if (done_b) begin nd_b++; dc_b = cyc - run_b; end
    busy_a_q = busy_a;
    busy_b_q = busy_b;
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] pix(input int base, input int k, input int lat);
    logic [2:0] c;
    c = 3'(base + k);
    return {8'(k % H), 1'b0, 7'(k / H), 5'b0, c, 8'(k + lat + 1)};
  endfunction

  function automatic bit keep(input int base, input int k);
    return !KEYED || (3'(base + k) != 3'd0);
  endfunction

  function automatic int n_keep(input int base, input int cnt);
    int n = 0;
    for (int k = 0; k < cnt; k++) if (keep(base, k)) n++;
    return n;
  endfunction

  task automatic clear_logs();
    np_a = 0; np_b = 0; nd_a = 0; nd_b = 0; nb_a = 0;
    dc_a = -1; dc_b = -1; run_a = 0; run_b = 0;
  endtask

  task automatic start_frame(input logic [1:0] sel);
    @(posedge clock); #1;
    img_sel = sel;
    start   = 1'b1;
    clear_logs();
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic check_frame(input int base, input string nm);
    int n = 0;
    for (int k = 0; k < W; k++) begin
      if (keep(base, k)) begin
        chk($sformatf("%s_a_px%0d", nm, k), log_a[n], pix(base, k, 1));
        chk($sformatf("%s_b_px%0d", nm, k), log_b[n], pix(base, k, 3));
        n++;
      end
    end
    chk({nm, "_plots_a"}, np_a, n);
    chk({nm, "_plots_b"}, np_b, n);
    chk({nm, "_ndone_a"}, nd_a, 1);
    chk({nm, "_ndone_b"}, nd_b, 1);
    chk({nm, "_tdone_a"}, dc_a, W + 2);
    chk({nm, "_tdone_b"}, dc_b, W + 4);
    chk({nm, "_addr_first"}, 32'(ra_log[0]), base);
    chk({nm, "_addr_last"}, 32'(ra_log[W-1]), base + W - 1);
  endtask

  initial begin
    clear_logs();
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_addr_a", 32'(rom_addr_a), 0);
    chk("rst_out_a", {out_x_a, out_y_a, out_col_a, plot_a, busy_a, done_a}, 0);
    chk("rst_addr_b", 32'(rom_addr_b), 0);
    chk("rst_out_b", {out_x_b, out_y_b, out_col_b, plot_b, busy_b, done_b}, 0);
    @(posedge clock); #1;
    resetn = 1'b1;

    start_frame(2'd1);
    repeat (40) @(negedge clock);
    check_frame(12, "img1");

    start_frame(2'd3);
    repeat (40) @(negedge clock);
    check_frame(24, "clamp");

    // Abort lands six edges after acceptance, mid-RUN.
    start_frame(2'd0);
    repeat (5) @(posedge clock);
    #1 abort = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
    chk("abort_plot_a", 32'(plot_a), 0);
    chk("abort_busy_a", 32'(busy_a), 0);
    chk("abort_plot_b", 32'(plot_b), 0);
    chk("abort_busy_b", 32'(busy_b), 0);
    repeat (30) @(negedge clock);
    chk("abort_ndone_a", nd_a, 0);
    chk("abort_ndone_b", nd_b, 0);
    chk("abort_plots_a", np_a, n_keep(0, 4));
    chk("abort_plots_b", np_b, n_keep(0, 2));

    start_frame(2'd0);
    repeat (40) @(negedge clock);
    check_frame(0, "post_abort");

    // Restart attempts and selection changes while busy must not disturb the frame.
    start_frame(2'd1);
    repeat (3) @(posedge clock);
    #1 start = 1'b1; img_sel = 2'd2;
    @(posedge clock); #1;
    start = 1'b0; img_sel = 2'd0;
    repeat (2) @(posedge clock);
    #1 img_sel = 2'd3;
    repeat (40) @(negedge clock);
    check_frame(12, "midstart");

    start_frame(2'd2);
    repeat (6) @(posedge clock);
    #2 resetn = 1'b0;
    #1;
    chk("areset_addr_a", 32'(rom_addr_a), 0);
    chk("areset_out_a", {out_x_a, out_y_a, out_col_a, plot_a, busy_a, done_a}, 0);
    chk("areset_addr_b", 32'(rom_addr_b), 0);
    chk("areset_out_b", {out_x_b, out_y_b, out_col_b, plot_b, busy_b, done_b}, 0);
    @(posedge clock); #1;
    resetn = 1'b1;
    repeat (30) @(negedge clock);
    chk("areset_ndone_a", nd_a, 0);
    chk("areset_ndone_b", nd_b, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
